// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at the input rate, zero-stuffing,
// N integrators at the output rate, gain compensation by arithmetic right
// shift and saturation to DATA_WIDTH. Produces R_l outputs per accepted
// sample (R_l in 1,2,4,..,MAX_INTERP) with one cycle of latency.
// Optional build macro: CIC_INT_ROUND_EN adds round-half-up before the
// gain shift; when undefined the shift truncates toward -inf.
module cic_interpolator #(
   parameter int DATA_WIDTH = 16,
   parameter int DATA_FRAC  = 15,
   parameter int N          = 1,
   parameter int MAX_INTERP = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          valid_in,
   output logic                          ready_in,
   input  logic [$clog2(MAX_INTERP):0]   interp_factor,
   input  logic signed [DATA_WIDTH-1:0]  cic_in,
   output logic signed [DATA_WIDTH-1:0]  cic_out,
   output logic                          valid_out,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int LOG2_MAX = $clog2(MAX_INTERP);
   localparam int RW       = LOG2_MAX + 1;
   localparam int PW       = (LOG2_MAX > 0) ? LOG2_MAX : 1;
   localparam int SW       = 8;
   localparam int ACC_W    = DATA_WIDTH + N * LOG2_MAX;
   localparam int EXT_W    = ACC_W + 1;

   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

   // Parameter sanity: catch unsupported configurations at elaboration.
   if (N < 1 || N > 4) begin : g_chk_n
      $error("cic_interpolator: N must be in 1..4");
   end
   if (DATA_FRAC >= DATA_WIDTH) begin : g_chk_frac
      $error("cic_interpolator: DATA_FRAC must be below DATA_WIDTH");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Maps a requested factor onto log2(R); anything that is not a power
   // of two within range falls back to R = 1.
   function automatic logic [SW-1:0] legal_log2(input logic [RW-1:0] f);
      logic [SW-1:0] l;
      l = {SW{1'b0}};
      for (int k = 0; k <= LOG2_MAX; k++) begin
         if (f == (RW'(1) << k)) begin
            l = SW'(k);
         end else begin
            l = l;
         end
      end
      return l;
   endfunction

   state_t                    state_r;
   logic [PW-1:0]             phase_r;
   logic [PW-1:0]             rlast_r;
   logic [SW-1:0]             shift_r;
   logic                      ready_r;
   logic signed [ACC_W-1:0]   dly_r   [N];
   logic signed [ACC_W-1:0]   integ_r [N];
   logic signed [DATA_WIDTH-1:0] cic_out_r;
   logic                      valid_r;
   logic                      ovf_r;
   logic                      udf_r;

   logic                      accept_s;
   logic                      emit_s;
   state_t                    state_nxt_s;
   logic [PW-1:0]             phase_nxt_s;
   logic [PW-1:0]             rlast_nxt_s;
   logic [SW-1:0]             shift_nxt_s;
   logic                      ready_nxt_s;
   logic [SW-1:0]             lg_new_s;
   logic [PW-1:0]             rlast_new_s;
   logic [SW-1:0]             shift_new_s;

   logic signed [ACC_W-1:0]   comb_s  [N+1];
   logic signed [ACC_W-1:0]   integ_s [N+1];
   logic signed [EXT_W-1:0]   ext_s;
   logic signed [EXT_W-1:0]   shifted_s;
`ifdef CIC_INT_ROUND_EN
   logic signed [EXT_W-1:0]   rnd_s;
`endif
   logic signed [DATA_WIDTH-1:0] sat_s;
   logic                      ovf_s;
   logic                      udf_s;

   // Sequencing: accept handshake, phase counter and the latched factor.
   always_comb begin
      lg_new_s    = legal_log2(interp_factor);
      rlast_new_s = PW'((32'd1 << lg_new_s) - 32'd1);
      shift_new_s = SW'(N - 1) * lg_new_s;
      accept_s    = valid_in && ready_r;
      state_nxt_s = state_r;
      phase_nxt_s = phase_r;
      rlast_nxt_s = rlast_r;
      shift_nxt_s = shift_r;
      emit_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_RUN;
               phase_nxt_s = {PW{1'b0}};
               rlast_nxt_s = rlast_new_s;
               shift_nxt_s = shift_new_s;
               emit_s      = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (phase_r == rlast_r) begin
               if (accept_s) begin
                  phase_nxt_s = {PW{1'b0}};
                  rlast_nxt_s = rlast_new_s;
                  shift_nxt_s = shift_new_s;
                  emit_s      = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
                  phase_nxt_s = {PW{1'b0}};
               end
            end else begin
               phase_nxt_s = phase_r + PW'(1);
               emit_s      = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            phase_nxt_s = {PW{1'b0}};
         end
      endcase
      ready_nxt_s = (state_nxt_s == ST_IDLE) || (phase_nxt_s == rlast_nxt_s);
   end

   // Datapath: comb chain on the incoming sample, zero-stuffed integrator
   // cascade, gain shift and saturation for the output being emitted.
   always_comb begin
      comb_s[0] = ACC_W'(cic_in);
      for (int k = 1; k <= N; k++) begin
         comb_s[k] = comb_s[k-1] - dly_r[k-1];
      end
      integ_s[0] = accept_s ? comb_s[N] : {ACC_W{1'b0}};
      for (int k = 1; k <= N; k++) begin
         integ_s[k] = integ_r[k-1] + integ_s[k-1];
      end
      ext_s = EXT_W'(integ_s[N]);
`ifdef CIC_INT_ROUND_EN
      if (shift_nxt_s != {SW{1'b0}}) begin
         rnd_s = signed'(EXT_W'(1) << (shift_nxt_s - SW'(1)));
      end else begin
         rnd_s = {EXT_W{1'b0}};
      end
      shifted_s = (ext_s + rnd_s) >>> shift_nxt_s;
`else
      shifted_s = ext_s >>> shift_nxt_s;
`endif
      if (shifted_s > SAT_MAX) begin
         sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         ovf_s = 1'b1;
         udf_s = 1'b0;
      end else if (shifted_s < SAT_MIN) begin
         sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         ovf_s = 1'b0;
         udf_s = 1'b1;
      end else begin
         sat_s = shifted_s[DATA_WIDTH-1:0];
         ovf_s = 1'b0;
         udf_s = 1'b0;
      end
   end

   // Control registers: state, phase, latched factor/shift and ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         phase_r <= {PW{1'b0}};
         rlast_r <= {PW{1'b0}};
         shift_r <= {SW{1'b0}};
         ready_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         phase_r <= phase_nxt_s;
         rlast_r <= rlast_nxt_s;
         shift_r <= shift_nxt_s;
         ready_r <= ready_nxt_s;
      end
   end

   // Filter state: comb delays advance per accepted sample, integrators
   // per emitted output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            dly_r[k]   <= {ACC_W{1'b0}};
            integ_r[k] <= {ACC_W{1'b0}};
         end
      end else begin
         if (accept_s) begin
            for (int k = 0; k < N; k++) begin
               dly_r[k] <= comb_s[k];
            end
         end
         if (emit_s) begin
            for (int k = 0; k < N; k++) begin
               integ_r[k] <= integ_s[k+1];
            end
         end
      end
   end

   // Output register: sample, valid and saturation flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cic_out_r <= {DATA_WIDTH{1'b0}};
         valid_r   <= 1'b0;
         ovf_r     <= 1'b0;
         udf_r     <= 1'b0;
      end else if (emit_s) begin
         cic_out_r <= sat_s;
         valid_r   <= 1'b1;
         ovf_r     <= ovf_s;
         udf_r     <= udf_s;
      end else begin
         valid_r   <= 1'b0;
         ovf_r     <= 1'b0;
         udf_r     <= 1'b0;
      end
   end

   assign ready_in  = ready_r;
   assign cic_out   = cic_out_r;
   assign valid_out = valid_r;
   assign overflow  = ovf_r;
   assign underflow = udf_r;

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: three instances (N=1,2,3) share the
// stimulus bus; each scenario task checks the instance it targets.
module tb_cic_interpolator;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [4:0]  interp_factor;
   logic [15:0] cic_in;

   logic        n1_ready, n1_valid, n1_ovf, n1_udf;
   logic [15:0] n1_out;
   logic        n2_ready, n2_valid, n2_ovf, n2_udf;
   logic [15:0] n2_out;
   logic        n3_ready, n3_valid, n3_ovf, n3_udf;
   logic [15:0] n3_out;

   int total = 0;
   int bad   = 0;

   cic_interpolator #(.DATA_WIDTH(16), .DATA_FRAC(15), .N(1), .MAX_INTERP(16)) u_n1 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(n1_ready),
      .interp_factor(interp_factor), .cic_in(cic_in), .cic_out(n1_out),
      .valid_out(n1_valid), .overflow(n1_ovf), .underflow(n1_udf));

   cic_interpolator #(.DATA_WIDTH(16), .DATA_FRAC(15), .N(2), .MAX_INTERP(16)) u_n2 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(n2_ready),
      .interp_factor(interp_factor), .cic_in(cic_in), .cic_out(n2_out),
      .valid_out(n2_valid), .overflow(n2_ovf), .underflow(n2_udf));

   cic_interpolator #(.DATA_WIDTH(16), .DATA_FRAC(15), .N(3), .MAX_INTERP(16)) u_n3 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(n3_ready),
      .interp_factor(interp_factor), .cic_in(cic_in), .cic_out(n3_out),
      .valid_out(n3_valid), .overflow(n3_ovf), .underflow(n3_udf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b1; valid_in = 1'b0; cic_in = 16'h0000; interp_factor = 5'd1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_in = 1'b0; cic_in = 16'h0000; interp_factor = 5'd1;
      repeat (2) @(negedge clk);
      total++; if (n1_out !== 16'h0000) begin bad++; $display("FAIL rst_out got=%h exp=0000", n1_out); end
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", n1_valid); end
      total++; if (n1_ovf !== 1'b0 || n1_udf !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", n1_ovf, n1_udf); end
      total++; if (n1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", n1_ready); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (n1_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", n1_ready); end
      total++; if (n3_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready_n3 got=%b exp=1", n3_ready); end
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", n1_valid); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_out;
      logic        exp_rdy;
      do_reset();
      interp_factor = 5'd4; cic_in = 16'h4000; valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_out = (i < 4) ? 16'h4000 : 16'h0000;
         exp_rdy = ((i % 4) == 3);
         total++; if (n1_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, n1_valid); end
         total++; if (n1_out !== exp_out) begin bad++; $display("FAIL b2b_out[%0d] got=%h exp=%h", i, n1_out, exp_out); end
         total++; if (n1_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, n1_ready, exp_rdy); end
         if (i == 0) cic_in = 16'h0000;
         if (i == 7) valid_in = 1'b0;
      end
      @(negedge clk);
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got=%b exp=0", n1_valid); end
   endtask

   task automatic test_ramp_r1();
      do_reset();
      interp_factor = 5'd1; cic_in = 16'h0001; valid_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         total++; if (n1_valid !== 1'b1) begin bad++; $display("FAIL ramp_valid[%0d] got=%b exp=1", k, n1_valid); end
         total++; if (n1_out !== 16'(k)) begin bad++; $display("FAIL ramp_out[%0d] got=%h exp=%h", k, n1_out, 16'(k)); end
         total++; if (n1_ready !== 1'b1) begin bad++; $display("FAIL ramp_ready[%0d] got=%b exp=1", k, n1_ready); end
         if (k < 8) cic_in = 16'(k + 1);
         else valid_in = 1'b0;
      end
      @(negedge clk);
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL ramp_idle_valid got=%b exp=0", n1_valid); end
      total++; if (n1_out !== 16'h0008) begin bad++; $display("FAIL ramp_hold got=%h exp=0008", n1_out); end
   endtask

   task automatic test_linear_n2();
      logic [15:0] exp_out;
      do_reset();
      interp_factor = 5'd2; cic_in = 16'h2000; valid_in = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_out = (k == 1) ? 16'h1000 : 16'h2000;
         total++; if (n2_valid !== 1'b1) begin bad++; $display("FAIL lin_valid[%0d] got=%b exp=1", k, n2_valid); end
         total++; if (n2_out !== exp_out) begin bad++; $display("FAIL lin_out[%0d] got=%h exp=%h", k, n2_out, exp_out); end
         total++; if (n2_ovf !== 1'b0 || n2_udf !== 1'b0) begin bad++; $display("FAIL lin_flags[%0d] got=%b%b exp=00", k, n2_ovf, n2_udf); end
         if (k == 7) valid_in = 1'b0;
      end
      @(negedge clk);
      total++; if (n2_valid !== 1'b0) begin bad++; $display("FAIL lin_idle_valid got=%b exp=0", n2_valid); end
   endtask

   task automatic test_settle_n3();
      int acc  = 0;
      int outs = 0;
      do_reset();
      interp_factor = 5'd16; cic_in = 16'h7FFF; valid_in = 1'b1;
      if (valid_in && n3_ready) acc++;
      for (int c = 0; c < 300 && outs < 128; c++) begin
         @(negedge clk);
         if (n3_valid) begin
            outs++;
            total++; if (n3_ovf !== 1'b0 || n3_udf !== 1'b0) begin bad++; $display("FAIL n3_flags[%0d] got=%b%b exp=00", outs, n3_ovf, n3_udf); end
            if (outs == 64) begin
               total++; if (n3_out !== 16'h7FFF) begin bad++; $display("FAIL n3_pos_settle got=%h exp=7fff", n3_out); end
            end
            if (outs == 128) begin
               total++; if (n3_out !== 16'h8000) begin bad++; $display("FAIL n3_neg_settle got=%h exp=8000", n3_out); end
            end
         end
         if (acc == 4) cic_in = 16'h8000;
         if (acc == 8) valid_in = 1'b0;
         if (valid_in && n3_ready) acc++;
      end
      valid_in = 1'b0;
      total++; if (outs != 128) begin bad++; $display("FAIL n3_out_count got=%0d exp=128", outs); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      interp_factor = 5'd8; cic_in = 16'h5555; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (n1_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", n1_valid); end
      rst = 1'b1;
      #1;
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", n1_valid); end
      total++; if (n1_out !== 16'h0000) begin bad++; $display("FAIL mid_rst_out got=%h exp=0000", n1_out); end
      total++; if (n1_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", n1_ready); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (n1_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b exp=1", n1_ready); end
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL mid_rel_valid got=%b exp=0", n1_valid); end
      interp_factor = 5'd8; cic_in = 16'h1234; valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) valid_in = 1'b0;
         total++; if (n1_valid !== 1'b1) begin bad++; $display("FAIL mid_new_valid[%0d] got=%b exp=1", i, n1_valid); end
         total++; if (n1_out !== 16'h1234) begin bad++; $display("FAIL mid_new_out[%0d] got=%h exp=1234", i, n1_out); end
      end
      @(negedge clk);
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL mid_end_valid got=%b exp=0", n1_valid); end
   endtask

   task automatic test_factor_handling();
      int cnt = 0;
      do_reset();
      interp_factor = 5'd3; cic_in = 16'h0100; valid_in = 1'b1;
      @(negedge clk);
      total++; if (n1_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b exp=1", n1_valid); end
      total++; if (n1_out !== 16'h0100) begin bad++; $display("FAIL ill_out got=%h exp=0100", n1_out); end
      total++; if (n1_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", n1_ready); end
      valid_in = 1'b0;
      @(negedge clk);
      total++; if (n1_valid !== 1'b0) begin bad++; $display("FAIL ill_single got=%b exp=0", n1_valid); end
      total++; if (n1_out !== 16'h0100) begin bad++; $display("FAIL ill_hold got=%h exp=0100", n1_out); end
      interp_factor = 5'd4; valid_in = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin interp_factor = 5'd2; valid_in = 1'b0; end
         if (n1_valid) cnt++;
      end
      total++; if (cnt != 4) begin bad++; $display("FAIL chg_burst_len got=%0d exp=4", cnt); end
      total++; if (n1_out !== 16'h0100) begin bad++; $display("FAIL chg_out got=%h exp=0100", n1_out); end
   endtask

   task automatic test_saturation(input logic [15:0] x, input logic [15:0] first_exp,
                                  input logic [15:0] sat_exp, input logic exp_ovf);
      int acc  = 0;
      int outs = 0;
      bit done = 1'b0;
      do_reset();
      interp_factor = 5'd16; cic_in = x; valid_in = 1'b1;
      if (valid_in && n2_ready) acc++;
      for (int c = 0; c < 100 && !done; c++) begin
         @(negedge clk);
         if (n2_valid) begin
            outs++;
            if (outs == 1) begin
               total++; if (n2_out !== first_exp) begin bad++; $display("FAIL sat_first got=%h exp=%h", n2_out, first_exp); end
               total++; if (n2_ovf !== 1'b0 || n2_udf !== 1'b0) begin bad++; $display("FAIL sat_first_flags got=%b%b exp=00", n2_ovf, n2_udf); end
            end
            if (outs == 33) begin
               done = 1'b1;
               total++; if (n2_out !== sat_exp) begin bad++; $display("FAIL sat_out got=%h exp=%h", n2_out, sat_exp); end
               total++; if (n2_ovf !== exp_ovf) begin bad++; $display("FAIL sat_ovf got=%b exp=%b", n2_ovf, exp_ovf); end
               total++; if (n2_udf !== !exp_ovf) begin bad++; $display("FAIL sat_udf got=%b exp=%b", n2_udf, !exp_ovf); end
            end
         end
         if (acc == 3) valid_in = 1'b0;
         if (acc == 2) interp_factor = 5'd1;
         if (valid_in && n2_ready) acc++;
      end
      valid_in = 1'b0;
      total++; if (!done) begin bad++; $display("FAIL sat_timeout got=%0d exp=33", outs); end
      @(negedge clk);
      total++; if (n2_valid !== 1'b0) begin bad++; $display("FAIL sat_idle_valid got=%b exp=0", n2_valid); end
      total++; if (n2_ovf !== 1'b0 || n2_udf !== 1'b0) begin bad++; $display("FAIL sat_idle_flags got=%b%b exp=00", n2_ovf, n2_udf); end
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; cic_in = 16'h0000; interp_factor = 5'd1;
      test_reset();
      test_back_to_back();
      test_ramp_r1();
      test_linear_n2();
      test_settle_n3();
      test_reset_mid_burst();
      test_factor_handling();
      test_saturation(16'h7FFF, 16'h07FF, 16'h7FFF, 1'b1);
      test_saturation(16'h8000, 16'hF800, 16'h8000, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
